// File: rtl/pit_wb_master_if.sv
// Command, response and Wishbone signals of the PIT bus initiator.
interface pit_wb_master_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 3
);
    // Command handshake
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [AWIDTH-1:0] cmd_adr_i;
    logic [DWIDTH-1:0] cmd_dat_i;
    logic [1:0]        cmd_sel_i;
    // Response handshake
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DWIDTH-1:0] rsp_dat_o;
    logic              rsp_err_o;
    // Wishbone classic
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AWIDTH-1:0] wb_adr_o;
    logic [DWIDTH-1:0] wb_dat_o;
    logic [1:0]        wb_sel_o;
    logic [DWIDTH-1:0] wb_dat_i;
    logic              wb_ack_i;
    // Status
    logic              busy_o;

    // Initiator view
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i,
        output busy_o
    );

    // Requester / target view
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i,
        input  busy_o
    );
endinterface

// File: rtl/pit_wb_master.sv
// Single-outstanding Wishbone classic initiator for the PIT register bus,
// with an ack timeout that turns a silent target into an error response.
module pit_wb_master #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned AWIDTH  = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    pit_wb_master_if.master  bus
);

    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned T_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic        TO_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] adr_q, adr_d;
    logic [DWIDTH-1:0] dat_q, dat_d;
    logic [1:0]        sel_q, sel_d;
    logic              stb_q, stb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_c;

    // Last permitted strobe cycle without ack
    assign timeout_c = TO_EN && (cnt_q == CNT_W'(T_LAST));

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        stb_d       = stb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    we_d    = bus.cmd_we_i;
                    adr_d   = bus.cmd_adr_i;
                    sel_d   = bus.cmd_sel_i;
                    dat_d   = bus.cmd_we_i ? bus.cmd_dat_i : '0;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus.wb_ack_i) begin
                    rsp_dat_d   = we_q ? '0 : bus.wb_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    dat_d       = '0;
                    state_d     = RESP;
                end else if (timeout_c) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    dat_d       = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            stb_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            stb_q       <= stb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Handshake status decoded straight from the state
    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE);

    assign bus.wb_cyc_o    = stb_q;
    assign bus.wb_stb_o    = stb_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_pit_wb_master.sv
// Scoreboard bench for pit_wb_master: a behavioural target acks after a
// per-command latency (0 = never), and responses are checked in order.
module tb_pit_wb_master;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pit_wb_master_if #(.DWIDTH(DW), .AWIDTH(AW)) ifc ();

    pit_wb_master #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (ifc)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [1:0]    sel;
        int            lat;    // strobe cycle that gets ack; 0 = never
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    txn_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc_cnt = 0;
    int   rdy_mode = 1;   // 0 random, 1 high, 2 low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: response from the target behaviour chosen for this command
    function automatic rsp_t model(input txn_t t);
        rsp_t r;
        r.err = (t.lat == 0);
        r.dat = (r.err || t.we) ? '0 : t.rdata;
        return r;
    endfunction

    function automatic txn_t mk(input logic we, input int adr, input logic [DW-1:0] dat,
                                input logic [1:0] sel, input int lat, input logic [DW-1:0] rdata);
        txn_t t;
        t.we = we; t.adr = AW'(adr); t.dat = dat; t.sel = sel; t.lat = lat; t.rdata = rdata;
        return t;
    endfunction

    always @(posedge clk) cyc_cnt++;

    // Response-ready driver
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       ifc.rsp_ready_i = ($urandom_range(2) != 0);
            1:       ifc.rsp_ready_i = 1'b1;
            default: ifc.rsp_ready_i = 1'b0;
        endcase
    end

    // Target model and bus monitor
    txn_t cur;
    int   k = 0;
    int   gap = 0;
    bit   in_bus = 0;
    bit   have_prev = 0;
    bit   bogus = 0;
    always @(negedge clk) begin
        if (rst) begin
            in_bus = 0; have_prev = 0;
            ifc.wb_ack_i = 1'b0;
            ifc.wb_dat_i = DW'($urandom);
        end else if (ifc.wb_stb_o) begin
            if (!in_bus) begin
                bogus = 0;
                if (bus_q.size() == 0) begin
                    chk("stb_unexpected", 32'(ifc.wb_stb_o), 0);
                    bogus = 1;
                    cur.lat = 1;
                end else begin
                    cur = bus_q.pop_front();
                end
                if (have_prev) chk("stb_gap", 32'(gap >= 2), 1);
                in_bus = 1; k = 0;
            end
            k++;
            if (!bogus) begin
                chk("wb_cyc", 32'(ifc.wb_cyc_o), 1);
                chk("wb_we",  32'(ifc.wb_we_o), 32'(cur.we));
                chk("wb_adr", 32'(ifc.wb_adr_o), 32'(cur.adr));
                chk("wb_sel", 32'(ifc.wb_sel_o), 32'(cur.sel));
                chk("wb_dat", 32'(ifc.wb_dat_o), cur.we ? 32'(cur.dat) : 0);
            end
            ifc.wb_ack_i = (cur.lat != 0) && (k == cur.lat);
            ifc.wb_dat_i = ifc.wb_ack_i ? cur.rdata : DW'($urandom);
        end else begin
            if (in_bus) begin
                chk("stb_len", 32'(k), (cur.lat == 0) ? TO : 32'(cur.lat));
                in_bus = 0; have_prev = 1; gap = 0;
            end
            gap++;
            // Stray acks while idle must be ignored
            ifc.wb_ack_i = !ifc.busy_o && ($urandom_range(3) == 0);
            ifc.wb_dat_i = DW'($urandom);
        end
    end

    // Response monitor
    rsp_t rexp;
    always @(negedge clk) begin
        if (!rst && ifc.rsp_valid_o && ifc.rsp_ready_i) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(ifc.rsp_valid_o), 0);
            end else begin
                rexp = rsp_q.pop_front();
                chk("rsp_dat", 32'(ifc.rsp_dat_o), 32'(rexp.dat));
                chk("rsp_err", 32'(ifc.rsp_err_o), 32'(rexp.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic wait_accept(output int acc);
        int n = 0;
        acc = -1;
        while (n < 200) begin
            @(negedge clk);
            if (ifc.cmd_ready_o) begin
                @(posedge clk); #1;
                acc = cyc_cnt;
                break;
            end
            n++;
        end
        if (acc < 0) chk("accept_wait", 32'(ifc.cmd_ready_o), 1);
    endtask

    task automatic drive(input txn_t t);
        ifc.cmd_valid_i = 1'b1;
        ifc.cmd_we_i    = t.we;
        ifc.cmd_adr_i   = t.adr;
        ifc.cmd_dat_i   = t.dat;
        ifc.cmd_sel_i   = t.sel;
    endtask

    task automatic issue(input txn_t t, output int acc);
        bus_q.push_back(t);
        rsp_q.push_back(model(t));
        drive(t);
        wait_accept(acc);
        ifc.cmd_valid_i = 1'b0;
        ifc.cmd_dat_i   = DW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || ifc.busy_o) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("drain", 32'(ifc.busy_o), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   acc, prev, n;
        int   lats[6];
        txn_t t;
        logic [DW-1:0] rd;

        lats = '{1, 2, 3, 0, 15, 5};
        rst = 1'b1;
        ifc.cmd_valid_i = 1'b0;
        ifc.cmd_we_i    = 1'b0;
        ifc.cmd_adr_i   = '0;
        ifc.cmd_dat_i   = '0;
        ifc.cmd_sel_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(ifc.cmd_ready_o), 1);
        chk("rst_busy",      32'(ifc.busy_o), 0);
        chk("rst_stb",       32'(ifc.wb_stb_o), 0);
        chk("rst_cyc",       32'(ifc.wb_cyc_o), 0);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid_o), 0);
        chk("rst_rsp_dat",   32'(ifc.rsp_dat_o), 0);
        chk("rst_rsp_err",   32'(ifc.rsp_err_o), 0);
        chk("rst_we",        32'(ifc.wb_we_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write, two-cycle target
        issue(mk(1'b1, 1, 16'hA55A, 2'b11, 2, DW'($urandom)), acc);
        drain();

        // Read latency: response valid three cycles after accept
        issue(mk(1'b0, 2, DW'($urandom), 2'b11, 2, 16'h1234), acc);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ifc.rsp_valid_o) break;
        end
        chk("rsp_latency", 32'(n), 3);
        drain();

        // Single-cycle target, timeout, recovery, ack on the timeout edge
        issue(mk(1'b0, 5, DW'($urandom), 2'b01, 1, 16'hBEEF), acc);
        issue(mk(1'b0, 3, DW'($urandom), 2'b10, 0, DW'($urandom)), acc);
        drain();
        issue(mk(1'b1, 4, 16'h0F0F, 2'b11, 1, DW'($urandom)), acc);
        issue(mk(1'b0, 6, DW'($urandom), 2'b11, TO, 16'h7E57), acc);
        drain();

        // Response backpressure with a pending command
        rdy_mode = 2;
        rd = 16'hC0DE;
        issue(mk(1'b0, 7, DW'($urandom), 2'b11, 2, rd), acc);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ifc.rsp_valid_o) break;
        end
        chk("bp_rsp_valid", 32'(ifc.rsp_valid_o), 1);
        @(posedge clk); #1;
        t = mk(1'b1, 0, 16'h5AA5, 2'b01, 2, DW'($urandom));
        bus_q.push_back(t);
        rsp_q.push_back(model(t));
        drive(t);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid",     32'(ifc.rsp_valid_o), 1);
            chk("bp_dat",       32'(ifc.rsp_dat_o), 32'(rd));
            chk("bp_err",       32'(ifc.rsp_err_o), 0);
            chk("bp_cmd_ready", 32'(ifc.cmd_ready_o), 0);
            chk("bp_stb",       32'(ifc.wb_stb_o), 0);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after", 32'(ifc.cmd_ready_o), 1);
        @(posedge clk); #1;
        ifc.cmd_valid_i = 1'b0;
        drain();

        // Reset on the first strobe cycle
        drive(mk(1'b0, 2, 16'h0, 2'b11, 0, 16'h0));
        @(negedge clk);
        chk("rb_cmd_ready", 32'(ifc.cmd_ready_o), 1);
        @(posedge clk); #1;
        ifc.cmd_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rb_stb_before", 32'(ifc.wb_stb_o), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rb_cyc",       32'(ifc.wb_cyc_o), 0);
        chk("rb_stb",       32'(ifc.wb_stb_o), 0);
        chk("rb_busy",      32'(ifc.busy_o), 0);
        chk("rb_cmd_ready", 32'(ifc.cmd_ready_o), 1);
        repeat (3) begin
            @(negedge clk);
            chk("rb_no_rsp", 32'(ifc.rsp_valid_o), 0);
        end
        @(posedge clk); #1;

        // Back-to-back stream, one accept every four cycles
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(mk(i[0], i, DW'($urandom), 2'b11, 2, DW'($urandom)), acc);
            if (prev >= 0) chk("stream_spacing", 32'(acc - prev), 4);
            prev = acc;
        end
        drain();

        // Randomized traffic
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            int g;
            issue(mk(1'(($urandom)), int'($urandom_range(7)), DW'($urandom),
                     2'($urandom), lats[$urandom_range(5)], DW'($urandom)), acc);
            g = int'($urandom_range(3));
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        drain();
        chk("queues_empty", 32'(rsp_q.size() + bus_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
